// File: rtl/step_seq_kbd_pkg.sv
// ---------------------------------------------------------------------------
// step_seq_kbd_pkg
// Shared definitions for the step-sequencer keyboard input path.
//   - PS/2 set-2 scancode constants (digits, ENTER, BACKSPACE, prefixes,
//     focus-switch keys)
//   - prefix FSM state encoding used by kbd_focus_arbiter
//   - isSwitchKey / switchTarget helpers, also used by the per-field input
//     controllers so that every block agrees on which keys move focus
// No ports (package).
// ---------------------------------------------------------------------------
package step_seq_kbd_pkg;

    // Digit make codes 0..9
    localparam logic [7:0] SC_0         = 8'h45;
    localparam logic [7:0] SC_1         = 8'h16;
    localparam logic [7:0] SC_2         = 8'h1E;
    localparam logic [7:0] SC_3         = 8'h26;
    localparam logic [7:0] SC_4         = 8'h25;
    localparam logic [7:0] SC_5         = 8'h2E;
    localparam logic [7:0] SC_6         = 8'h36;
    localparam logic [7:0] SC_7         = 8'h3D;
    localparam logic [7:0] SC_8         = 8'h3E;
    localparam logic [7:0] SC_9         = 8'h46;

    // Editing keys
    localparam logic [7:0] SC_ENTER     = 8'h5A;
    localparam logic [7:0] SC_BACKSPACE = 8'h66;

    // Prefix bytes: extended key and break (key release)
    localparam logic [7:0] SC_E0        = 8'hE0;
    localparam logic [7:0] SC_F0        = 8'hF0;

    // Focus-switch keys
    localparam logic [7:0] SC_F1        = 8'h05;
    localparam logic [7:0] SC_F2        = 8'h06;
    localparam logic [7:0] SC_F3        = 8'h04;
    localparam logic [7:0] SC_F4        = 8'h0C;
    localparam logic [7:0] SC_ESC       = 8'h76;

    // Prefix FSM; FLUSH drains the byte queue one byte per cycle
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GOT_E0   = 3'd1,
        ST_GOT_F0   = 3'd2,
        ST_GOT_E0F0 = 3'd3,
        ST_FLUSH    = 3'd4
    } prefix_state_t;

    // True when the code moves focus in a system with n_targets editors.
    // Fn beyond the number of editors is an ordinary key; ESC always counts.
    function automatic logic isSwitchKey(input logic [7:0] code, input int n_targets);
        logic hit;
        hit = 1'b0;
        case (code)
            SC_F1:   hit = (n_targets >= 1);
            SC_F2:   hit = (n_targets >= 2);
            SC_F3:   hit = (n_targets >= 3);
            SC_F4:   hit = (n_targets >= 4);
            SC_ESC:  hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Focus id selected by a switch key: 0 = none, k = target k-1
    function automatic logic [2:0] switchTarget(input logic [7:0] code);
        logic [2:0] id;
        id = 3'd0;
        case (code)
            SC_F1:   id = 3'd1;
            SC_F2:   id = 3'd2;
            SC_F3:   id = 3'd3;
            SC_F4:   id = 3'd4;
            default: id = 3'd0;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/kbd_byte_queue.sv
// ---------------------------------------------------------------------------
// kbd_byte_queue
// 3-entry shift queue for held prefix bytes plus the byte that released them.
// A push (1..3 bytes, byte 0 first) is only accepted while the queue is
// empty; the owner never pushes while draining. When pushing and popping in
// the same cycle, the first pushed byte leaves immediately through 'head',
// which lets the owner emit it without an extra cycle of latency.
// Ports:
//   Clock      in   rising-edge clock
//   nReset     in   asynchronous active-low reset, empties the queue
//   push_cnt   in   number of bytes to push (0 = no push)
//   push_data  in   pushed bytes, [7:0] = oldest
//   pop        in   remove the head byte
//   head       out  oldest byte (push_data[7:0] when empty)
//   count      out  number of stored bytes
//   empty      out  no stored bytes
// ---------------------------------------------------------------------------
module kbd_byte_queue (
    input  logic        Clock,
    input  logic        nReset,
    input  logic [1:0]  push_cnt,
    input  logic [23:0] push_data,
    input  logic        pop,
    output logic [7:0]  head,
    output logic [1:0]  count,
    output logic        empty
);

    logic [7:0] mem [3];
    logic [1:0] cnt;

    assign empty = (cnt == 2'd0);
    assign count = cnt;
    // Bypass: with nothing stored the oldest byte is the one being pushed
    assign head  = empty ? push_data[7:0] : mem[0];

    // Storage: shift toward entry 0 on pop, load on push into an empty queue
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            cnt    <= 2'd0;
            mem[0] <= 8'h00;
            mem[1] <= 8'h00;
            mem[2] <= 8'h00;
        end else if (!empty) begin
            if (pop) begin
                mem[0] <= mem[1];
                mem[1] <= mem[2];
                mem[2] <= 8'h00;
                cnt    <= cnt - 2'd1;
            end
        end else if (push_cnt != 2'd0) begin
            if (pop) begin
                mem[0] <= push_data[15:8];
                mem[1] <= push_data[23:16];
                mem[2] <= 8'h00;
                cnt    <= push_cnt - 2'd1;
            end else begin
                mem[0] <= push_data[7:0];
                mem[1] <= push_data[15:8];
                mem[2] <= push_data[23:16];
                cnt    <= push_cnt;
            end
        end
    end

endmodule

// File: rtl/kbd_focus_arbiter.sv
// ---------------------------------------------------------------------------
// kbd_focus_arbiter
// Routes the PS/2 scancode stream to one of up to four keyboard editors.
// F1..F4 give focus to editor 0..3, ESC releases focus. Switch keys and
// their E0/F0 sequences are swallowed; every other byte, together with any
// held prefixes, is forwarded in arrival order to the focused editor.
// Optional feature macro: FOCUS_TIMEOUT_EN (idle auto-release of focus).
// Parameters:
//   N_TARGETS       number of editors, 1..4
//   RESET_FOCUS     focus after reset (0 = none, k = target k-1)
//   TIMEOUT_CYCLES  idle cycles before auto-release (FOCUS_TIMEOUT_EN only)
// Ports:
//   Clock     in   rising-edge clock
//   nReset    in   asynchronous active-low reset
//   data      in   received scancode byte
//   data_en   in   one-cycle strobe, data valid
//   Enable    out  one-hot focus, all zero when no editor has focus
//   fwd_data  out  forwarded byte, shared by all editors
//   fwd_en    out  one-cycle strobe on the focused editor's bit
//   focus_id  out  0 = none, k = target k-1
//   overrun   out  one-cycle pulse when a byte arrived during a flush
// ---------------------------------------------------------------------------
module kbd_focus_arbiter
    import step_seq_kbd_pkg::*;
#(
    parameter int          N_TARGETS      = 4,
    parameter int          RESET_FOCUS    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic [7:0]           data,
    input  logic                 data_en,
    output logic [N_TARGETS-1:0] Enable,
    output logic [7:0]           fwd_data,
    output logic [N_TARGETS-1:0] fwd_en,
    output logic [2:0]           focus_id,
    output logic                 overrun
);

    if (N_TARGETS < 1 || N_TARGETS > 4 || RESET_FOCUS < 0 || RESET_FOCUS > N_TARGETS
        || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("kbd_focus_arbiter: parameter out of range");
    end

    prefix_state_t state, state_next;
    logic [2:0]    focus_next;
    logic [1:0]    held_cnt;
    logic [15:0]   held_bytes;
    logic [1:0]    push_cnt;
    logic [23:0]   push_data;
    logic          pop;
    logic          emit;
    logic          overrun_next;
    logic          is_switch;
    logic [7:0]    q_head;
    logic [1:0]    q_count;
    logic          q_empty;
    logic          timeout_hit;

    kbd_byte_queue u_queue (
        .Clock     (Clock),
        .nReset    (nReset),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .pop       (pop),
        .head      (q_head),
        .count     (q_count),
        .empty     (q_empty)
    );

    // One-hot editor enable decoded from the focus register
    always_comb begin
        for (int i = 0; i < N_TARGETS; i++) begin
            Enable[i] = (focus_id == 3'(i + 1));
        end
    end

`ifdef FOCUS_TIMEOUT_EN
    logic [31:0] idle_cnt;

    // Idle counter, cleared by any received byte and saturating at all-ones
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            idle_cnt <= '0;
        end else if (data_en) begin
            idle_cnt <= '0;
        end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    // Using >= so a timeout reached mid-sequence fires once back in IDLE
    assign timeout_hit = !data_en && (state == ST_IDLE) && (focus_id != 3'd0)
                         && (idle_cnt >= 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Prefixes implied by the current state, oldest in the low byte
    always_comb begin
        held_cnt   = 2'd0;
        held_bytes = 16'h0000;
        case (state)
            ST_GOT_E0: begin
                held_cnt   = 2'd1;
                held_bytes = {8'h00, SC_E0};
            end
            ST_GOT_F0: begin
                held_cnt   = 2'd1;
                held_bytes = {8'h00, SC_F0};
            end
            ST_GOT_E0F0: begin
                held_cnt   = 2'd2;
                held_bytes = {SC_F0, SC_E0};
            end
            default: ;
        endcase
    end

    // Next-state, focus and emission decisions
    always_comb begin
        state_next   = state;
        focus_next   = focus_id;
        push_cnt     = 2'd0;
        push_data    = 24'h000000;
        pop          = 1'b0;
        emit         = 1'b0;
        overrun_next = 1'b0;
        is_switch    = isSwitchKey(data, N_TARGETS);

        if (state == ST_FLUSH) begin
            // Bytes arriving now are dropped; the flush carries on untouched
            overrun_next = data_en;
            if (!q_empty) begin
                pop  = 1'b1;
                emit = 1'b1;
            end
            if (q_count <= 2'd1) begin
                state_next = ST_IDLE;
            end
        end else if (data_en) begin
            if (state == ST_IDLE && data == SC_E0) begin
                state_next = ST_GOT_E0;
            end else if (state == ST_IDLE && data == SC_F0) begin
                state_next = ST_GOT_F0;
            end else if (state == ST_GOT_E0 && data == SC_F0) begin
                state_next = ST_GOT_E0F0;
            end else if ((state == ST_IDLE || state == ST_GOT_F0) && is_switch) begin
                // Swallow the switch key and its prefix; only a make code moves focus
                state_next = ST_IDLE;
                if (state == ST_IDLE) begin
                    focus_next = switchTarget(data);
                end
            end else begin
                // Queue held prefixes plus this byte; the oldest leaves right away
                push_cnt = held_cnt + 2'd1;
                case (held_cnt)
                    2'd1:    push_data = {8'h00, data, held_bytes[7:0]};
                    2'd2:    push_data = {data, held_bytes};
                    default: push_data = {16'h0000, data};
                endcase
                pop        = 1'b1;
                emit       = 1'b1;
                state_next = (held_cnt == 2'd0) ? ST_IDLE : ST_FLUSH;
            end
        end

        if (timeout_hit) begin
            focus_next = 3'd0;
        end
    end

    // State and output registers
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state    <= ST_IDLE;
            focus_id <= 3'(RESET_FOCUS);
            fwd_data <= 8'h00;
            fwd_en   <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_next;
            focus_id <= focus_next;
            overrun  <= overrun_next;
            fwd_en   <= emit ? Enable : '0;
            if (emit) begin
                fwd_data <= q_head;
            end
        end
    end

endmodule
